// File: rtl/fb_loader.sv
// Byte-stream framebuffer loader: assembles 16-bit pixels from a valid/ready byte
// stream and writes them row-major into the scan driver's RAM, with a fill command.
module fb_loader #(
  parameter int          WIDTH      = 32,
  parameter int          HEIGHT     = 16,
  parameter int          ADDR_WIDTH = 16,
  parameter int          TIMEOUT    = 1_000_000,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter logic [7:0]  FILL_BYTE  = 8'h5A
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [15:0]           write_value,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  error
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(N - 1);
  localparam logic [CW-1:0]         TIME_LIMIT = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, PIX_LO, PIX_HI, FILL_LO, FILL_HI, FILL_RUN, DONE
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   index, index_next;
  logic [7:0]              lo, lo_next;
  logic [15:0]             fill_value, fill_value_next;
  logic [CW-1:0]           count, count_next;
  logic                    write_enable_next;
  logic [ADDR_WIDTH-1:0]   write_address_next;
  logic [15:0]             write_value_next;
  logic                    frame_done_next;
  logic                    error_next;
  logic                    accept;
  logic                    timed;

  assign in_ready = (state == IDLE) || (state == PIX_LO) || (state == PIX_HI) ||
                    (state == FILL_LO) || (state == FILL_HI);
  assign timed    = (state == PIX_LO) || (state == PIX_HI) ||
                    (state == FILL_LO) || (state == FILL_HI);
  assign accept   = in_valid && in_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      index         <= '0;
      lo            <= '0;
      fill_value    <= '0;
      count         <= '0;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_value   <= '0;
      frame_done    <= 1'b0;
      error         <= 1'b0;
    end else begin
      state         <= state_next;
      index         <= index_next;
      lo            <= lo_next;
      fill_value    <= fill_value_next;
      count         <= count_next;
      write_enable  <= write_enable_next;
      write_address <= write_address_next;
      write_value   <= write_value_next;
      frame_done    <= frame_done_next;
      error         <= error_next;
    end
  end

  always_comb begin
    state_next         = state;
    index_next         = index;
    lo_next            = lo;
    fill_value_next    = fill_value;
    write_enable_next  = 1'b0;
    write_address_next = write_address;
    write_value_next   = write_value;
    // DONE is entered together with the last write, so the pulse lands one cycle later
    frame_done_next    = (state == DONE);
    error_next         = 1'b0;
    count_next         = (accept || !timed) ? '0 : count + CW'(1);

    case (state)
      IDLE: begin
        if (accept) begin
          if (in_data == SYNC_BYTE) begin
            state_next = PIX_LO;
            index_next = '0;
          end else if (in_data == FILL_BYTE) begin
            state_next = FILL_LO;
          end
        end
      end
      PIX_LO: begin
        if (accept) begin
          lo_next    = in_data;
          state_next = PIX_HI;
        end
      end
      PIX_HI: begin
        if (accept) begin
          write_enable_next  = 1'b1;
          write_address_next = index;
          write_value_next   = {in_data, lo};
          if (index == LAST_INDEX) begin
            state_next = DONE;
          end else begin
            index_next = index + ADDR_WIDTH'(1);
            state_next = PIX_LO;
          end
        end
      end
      FILL_LO: begin
        if (accept) begin
          lo_next    = in_data;
          state_next = FILL_HI;
        end
      end
      FILL_HI: begin
        if (accept) begin
          fill_value_next = {in_data, lo};
          index_next      = '0;
          state_next      = FILL_RUN;
        end
      end
      FILL_RUN: begin
        write_enable_next  = 1'b1;
        write_address_next = index;
        write_value_next   = fill_value;
        if (index == LAST_INDEX) begin
          state_next = DONE;
        end else begin
          index_next = index + ADDR_WIDTH'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // An accepted byte always beats the timeout in the same cycle
    if (timed && !accept && (count == TIME_LIMIT)) begin
      state_next = IDLE;
      error_next = 1'b1;
      count_next = '0;
    end
  end

endmodule
